// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte helpers used by the key schedule and the round stages.
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {StIdle, StSub, StXor, StDone} kx_state_e;

   localparam int unsigned NR        = 10;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   // Forward S-box, entry 0 first; also used by the final round stage.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

endpackage

// File: rtl/sub_word_reg.sv
// SubWord: four S-box byte lookups with a registered 32-bit result (1-cycle latency).
module sub_word_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   output logic [31:0] dout
);
   import aes_pkg::*;

   word_t sub_d, sub_q;

   assign sub_d = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= '0;
      end else begin
         sub_q <= sub_d;
      end
   end

   assign dout = sub_q;

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: two cycles per round key, all 11 round keys held in flops.
// Optional AES_KEY_ZEROIZE_EN adds a zeroize input that wipes storage with top priority.
module aes128_key_expand (
   input  logic          clk,
   input  logic          rst_n,
`ifdef AES_KEY_ZEROIZE_EN
   input  logic          zeroize,
`endif
   input  logic [127:0]  key_in,
   input  logic          key_load,
   output logic          key_ready,
   output logic          keys_valid,
   output logic [1407:0] rk_bus,
   input  logic [3:0]    rk_idx,
   output logic [127:0]  rk_out
);
   import aes_pkg::*;

   kx_state_e          state_q, state_d;
   logic [3:0]         round_q, round_d;
   logic [7:0]         rcon_q, rcon_d;
   block_t             w_q, w_d;
   logic [NR:0][127:0] rk_q, rk_d;
   block_t             rk_out_q, rk_out_d;
   logic               valid_q, valid_d;
   logic               clear;
   word_t              sub_in, sub_out, t, w0n, w1n, w2n, w3n;

`ifdef AES_KEY_ZEROIZE_EN
   assign clear = zeroize;
`else
   assign clear = 1'b0;
`endif

   // RotWord of w3; the lookup result is consumed one cycle later in StXor.
   assign sub_in = {w_q[23:0], w_q[31:24]};

   sub_word_reg u_sub_word (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sub_in),
      .dout  (sub_out)
   );

   assign t   = sub_out ^ {rcon_q, 24'h0};
   assign w0n = w_q[127:96] ^ t;
   assign w1n = w_q[95:64] ^ w0n;
   assign w2n = w_q[63:32] ^ w1n;
   assign w3n = w_q[31:0] ^ w2n;

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      rcon_d   = rcon_q;
      w_d      = w_q;
      rk_d     = rk_q;
      valid_d  = valid_q;
      rk_out_d = (rk_idx <= 4'(NR)) ? rk_q[rk_idx] : '0;
      if (clear) begin
         state_d  = StIdle;
         round_d  = 4'd1;
         rcon_d   = RCON_INIT;
         w_d      = '0;
         rk_d     = '0;
         valid_d  = 1'b0;
         rk_out_d = '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (key_load) begin
                  rk_d[0] = key_in;
                  w_d     = key_in;
                  rcon_d  = RCON_INIT;
                  round_d = 4'd1;
                  valid_d = 1'b0;
                  state_d = StSub;
               end
            end
            StSub: state_d = StXor;
            StXor: begin
               rk_d[round_q] = {w0n, w1n, w2n, w3n};
               w_d           = {w0n, w1n, w2n, w3n};
               rcon_d        = xtime(rcon_q);
               round_d       = round_q + 4'd1;
               if (round_q == 4'(NR)) begin
                  state_d = StDone;
                  valid_d = 1'b1;
               end else begin
                  state_d = StSub;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         round_q  <= 4'd1;
         rcon_q   <= RCON_INIT;
         w_q      <= '0;
         rk_q     <= '0;
         rk_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         rcon_q   <= rcon_d;
         w_q      <= w_d;
         rk_q     <= rk_d;
         rk_out_q <= rk_out_d;
         valid_q  <= valid_d;
      end
   end

   assign key_ready  = (state_q == StIdle) || (state_q == StDone);
   assign keys_valid = valid_q;
   assign rk_bus     = rk_q;
   assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand against FIPS-197 and all-zero-key schedules.
module tb_aes128_key_expand;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [127:0]  key_in = '0;
   logic          key_load = 1'b0;
   logic [3:0]    rk_idx = '0;
   logic          key_ready, keys_valid;
   logic [1407:0] rk_bus;
   logic [127:0]  rk_out;
`ifdef AES_KEY_ZEROIZE_EN
   logic          zeroize = 1'b0;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes128_key_expand dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef AES_KEY_ZEROIZE_EN
      .zeroize    (zeroize),
`endif
      .key_in     (key_in),
      .key_load   (key_load),
      .key_ready  (key_ready),
      .keys_valid (keys_valid),
      .rk_bus     (rk_bus),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out)
   );

   function automatic logic [127:0] zero_rk(input int r);
      case (r)
         0:  return 128'h00000000000000000000000000000000;
         1:  return 128'h62636363626363636263636362636363;
         2:  return 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
         3:  return 128'h90973450696ccffaf2f457330b0fac99;
         4:  return 128'hee06da7b876a1581759e42b27e91ee2b;
         5:  return 128'h7f2e2b88f8443e098dda7cbbf34b9290;
         6:  return 128'hec614b851425758c99ff09376ab49ba7;
         7:  return 128'h217517873550620bacaf6b3cc61bf09b;
         8:  return 128'h0ef903333ba9613897060a04511dfa9f;
         9:  return 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
         10: return 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
         default: return 128'h0;
      endcase
   endfunction

   function automatic logic [127:0] rk_slice(input int r);
      return rk_bus[128*r +: 128];
   endfunction

   // Present a key for one edge; returns 1ns after the accept edge.
   task automatic do_load(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      @(posedge clk); #1;
      key_load = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int cycles);
      cycles = start;
      while (!keys_valid && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if (rk_bus !== '0) begin n_fail++; $display("FAIL reset_rk_bus: got %h want 0", rk_bus); end
      n_checks++;
      if (rk_out !== '0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
      n_checks++;
      if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", keys_valid); end
      n_checks++;
      if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", key_ready); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (key_ready !== 1'b1 || keys_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: ready %b valid %b want 1 0", key_ready, keys_valid);
      end
   endtask

   task automatic test_fips;
      int c;
      do_load(FIPS_KEY);
      wait_valid(0, c);
      n_checks++;
      if (c !== 20) begin n_fail++; $display("FAIL fips_latency: got %0d want 20", c); end
      n_checks++;
      if (rk_slice(0) !== FIPS_KEY) begin n_fail++; $display("FAIL fips_rk0: got %h want %h", rk_slice(0), FIPS_KEY); end
      n_checks++;
      if (rk_slice(1) !== FIPS_RK1) begin n_fail++; $display("FAIL fips_rk1: got %h want %h", rk_slice(1), FIPS_RK1); end
      n_checks++;
      if (rk_slice(2) !== FIPS_RK2) begin n_fail++; $display("FAIL fips_rk2: got %h want %h", rk_slice(2), FIPS_RK2); end
      n_checks++;
      if (rk_slice(10) !== FIPS_RK10) begin n_fail++; $display("FAIL fips_rk10: got %h want %h", rk_slice(10), FIPS_RK10); end
      n_checks++;
      if (key_ready !== 1'b1) begin n_fail++; $display("FAIL done_ready: got %b want 1", key_ready); end
   endtask

   task automatic test_reload_zero;
      int c;
      rk_idx = 4'd1;
      do_load('0);
      n_checks++;
      if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reload_valid_drop: got %b want 0", keys_valid); end
      n_checks++;
      if (rk_slice(0) !== '0) begin n_fail++; $display("FAIL reload_rk0: got %h want 0", rk_slice(0)); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (rk_out !== FIPS_RK1) begin n_fail++; $display("FAIL same_edge_read: got %h want %h", rk_out, FIPS_RK1); end
      n_checks++;
      if (rk_slice(1) !== zero_rk(1)) begin n_fail++; $display("FAIL reload_rk1: got %h want %h", rk_slice(1), zero_rk(1)); end
      n_checks++;
      if (rk_slice(10) !== FIPS_RK10) begin n_fail++; $display("FAIL stale_rk10: got %h want %h", rk_slice(10), FIPS_RK10); end
      wait_valid(2, c);
      n_checks++;
      if (c !== 20) begin n_fail++; $display("FAIL reload_latency: got %0d want 20", c); end
      n_checks++;
      if (rk_slice(10) !== zero_rk(10)) begin n_fail++; $display("FAIL reload_rk10: got %h want %h", rk_slice(10), zero_rk(10)); end
   endtask

   task automatic test_read_port;
      for (int i = 0; i <= 12; i++) begin
         int idx;
         idx = (i == 11) ? 11 : ((i == 12) ? 15 : i);
         rk_idx = 4'(idx);
         @(posedge clk); #1;
         n_checks++;
         if (rk_out !== zero_rk(idx)) begin
            n_fail++; $display("FAIL read_idx%0d: got %h want %h", idx, rk_out, zero_rk(idx));
         end
      end
   endtask

   task automatic test_busy_load;
      int  c;
      logic ready_hit;
      ready_hit = 1'b0;
      do_load(FIPS_KEY);
      c = 0;
      while (!keys_valid && c < 40) begin
         if (c == 4) begin
            key_in   = '0;
            key_load = 1'b1;
         end else begin
            key_load = 1'b0;
         end
         if (key_ready) ready_hit = 1'b1;
         @(posedge clk); #1;
         c++;
      end
      key_load = 1'b0;
      n_checks++;
      if (ready_hit !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", ready_hit); end
      n_checks++;
      if (c !== 20) begin n_fail++; $display("FAIL busy_latency: got %0d want 20", c); end
      n_checks++;
      if (rk_slice(0) !== FIPS_KEY) begin n_fail++; $display("FAIL busy_rk0: got %h want %h", rk_slice(0), FIPS_KEY); end
      n_checks++;
      if (rk_slice(1) !== FIPS_RK1) begin n_fail++; $display("FAIL busy_rk1: got %h want %h", rk_slice(1), FIPS_RK1); end
      n_checks++;
      if (rk_slice(10) !== FIPS_RK10) begin n_fail++; $display("FAIL busy_rk10: got %h want %h", rk_slice(10), FIPS_RK10); end
   endtask

   task automatic test_async_reset;
      rk_idx = 4'd0;
      do_load(FIPS_KEY);
      repeat (7) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (rk_bus !== '0) begin n_fail++; $display("FAIL async_rk_bus: got %h want 0", rk_bus); end
      n_checks++;
      if (rk_out !== '0) begin n_fail++; $display("FAIL async_rk_out: got %h want 0", rk_out); end
      n_checks++;
      if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", keys_valid); end
      n_checks++;
      if (key_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b want 1", key_ready); end
      #10 rst_n = 1'b1;
      repeat (25) begin @(posedge clk); #1; end
      n_checks++;
      if (keys_valid !== 1'b0 || rk_bus !== '0) begin
         n_fail++; $display("FAIL async_no_partial: valid %b bus_nonzero %b want 0 0", keys_valid, |rk_bus);
      end
   endtask

`ifdef AES_KEY_ZEROIZE_EN
   task automatic test_zeroize;
      int c;
      rk_idx = 4'd0;
      do_load(FIPS_KEY);
      repeat (6) begin @(posedge clk); #1; end
      zeroize  = 1'b1;
      key_load = 1'b1;
      key_in   = FIPS_KEY;
      @(posedge clk); #1;
      zeroize  = 1'b0;
      key_load = 1'b0;
      n_checks++;
      if (rk_bus !== '0) begin n_fail++; $display("FAIL zeroize_rk_bus: got %h want 0", rk_bus); end
      n_checks++;
      if (rk_out !== '0) begin n_fail++; $display("FAIL zeroize_rk_out: got %h want 0", rk_out); end
      n_checks++;
      if (key_ready !== 1'b1 || keys_valid !== 1'b0) begin
         n_fail++; $display("FAIL zeroize_state: ready %b valid %b want 1 0", key_ready, keys_valid);
      end
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (rk_bus !== '0 || key_ready !== 1'b1) begin
         n_fail++; $display("FAIL zeroize_idle: bus_nonzero %b ready %b want 0 1", |rk_bus, key_ready);
      end
      do_load('0);
      wait_valid(0, c);
      n_checks++;
      if (c !== 20) begin n_fail++; $display("FAIL zeroize_relatency: got %0d want 20", c); end
      n_checks++;
      if (rk_slice(10) !== zero_rk(10)) begin n_fail++; $display("FAIL zeroize_rk10: got %h want %h", rk_slice(10), zero_rk(10)); end
   endtask
`endif

   initial begin
      test_reset();
      test_fips();
      test_reload_zero();
      test_read_port();
      test_busy_load();
      test_async_reset();
`ifdef AES_KEY_ZEROIZE_EN
      test_zeroize();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
